// File: rtl/kbd_pkg.sv
// ============================================================================
// Module      : kbd_pkg
// Description : Shared types, scan-code constants and key map for the PS/2
//               key controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } kbd_state_t;

  localparam logic [7:0] PFX_EXT     = 8'hE0;
  localparam logic [7:0] PFX_BRK     = 8'hF0;
  localparam logic [7:0] CODE_BAT_OK = 8'hAA;
  localparam logic [7:0] CODE_ACK    = 8'hFA;
  localparam logic [7:0] CODE_ECHO   = 8'hEE;
  localparam logic [7:0] CODE_RESEND = 8'hFE;

  localparam int NUM_KEYS = 10;
  localparam int EVT_W    = 5;

  localparam logic [3:0] KEY_UP    = 4'd0;
  localparam logic [3:0] KEY_DOWN  = 4'd1;
  localparam logic [3:0] KEY_LEFT  = 4'd2;
  localparam logic [3:0] KEY_RIGHT = 4'd3;
  localparam logic [3:0] KEY_W     = 4'd4;
  localparam logic [3:0] KEY_A     = 4'd5;
  localparam logic [3:0] KEY_S     = 4'd6;
  localparam logic [3:0] KEY_D     = 4'd7;
  localparam logic [3:0] KEY_SPACE = 4'd8;
  localparam logic [3:0] KEY_ESC   = 4'd9;

  // Returns {hit, key_idx}; hit=0 for codes outside the game key set.
  function automatic logic [4:0] key_lookup(input logic ext, input logic [7:0] code);
    logic [4:0] r;
    r = '0;
    case ({ext, code})
      9'h175:  r = {1'b1, KEY_UP};
      9'h172:  r = {1'b1, KEY_DOWN};
      9'h16B:  r = {1'b1, KEY_LEFT};
      9'h174:  r = {1'b1, KEY_RIGHT};
      9'h01D:  r = {1'b1, KEY_W};
      9'h01C:  r = {1'b1, KEY_A};
      9'h01B:  r = {1'b1, KEY_S};
      9'h023:  r = {1'b1, KEY_D};
      9'h029:  r = {1'b1, KEY_SPACE};
      9'h076:  r = {1'b1, KEY_ESC};
      default: r = '0;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_evt_fifo.sv
// ============================================================================
// Module      : ps2_evt_fifo
// Description : Synchronous event FIFO with registered head data (0 when empty).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_evt_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 5
) (
  input  logic         clk,
  input  logic         ar,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] C_FULL = (PW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd, w_rd_nxt;
  logic [PW:0]   r_cnt, w_cnt_nxt;
  logic          w_push_ok, w_pop_ok;
  logic [W-1:0]  w_dout_nxt;

  assign empty     = (r_cnt == '0);
  assign full      = (r_cnt == C_FULL);
  assign w_pop_ok  = pop & ~empty;
  assign w_push_ok = push & (~full | w_pop_ok);

  // Head for next cycle; bypass din when the written slot becomes the head.
  always_comb begin
    w_rd_nxt  = w_pop_ok ? r_rd + 1'b1 : r_rd;
    w_cnt_nxt = r_cnt;
    if (w_push_ok && !w_pop_ok)
      w_cnt_nxt = r_cnt + 1'b1;
    else if (!w_push_ok && w_pop_ok)
      w_cnt_nxt = r_cnt - 1'b1;
    if (w_cnt_nxt == '0)
      w_dout_nxt = '0;
    else if (w_push_ok && (w_rd_nxt == r_wr))
      w_dout_nxt = din;
    else
      w_dout_nxt = r_mem[w_rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (w_push_ok)
      r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
      dout  <= '0;
    end else begin
      if (w_push_ok)
        r_wr <= r_wr + 1'b1;
      r_rd  <= w_rd_nxt;
      r_cnt <= w_cnt_nxt;
      dout  <= w_dout_nxt;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_key_ctrl.sv
// ============================================================================
// Module      : ps2_key_ctrl
// Description : PS/2 set-2 scan-code sequencer: byte sync, prefix FSM, held-key
//               bitmap and press/release event queue. Optional auto-repeat
//               suppression with macro TYPEMATIC_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ps2_key_ctrl
  import kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                clk,
  input  logic                ar,
  input  logic [7:0]          rx_byte,
  input  logic                rx_rdy,
  output logic [NUM_KEYS-1:0] key_state,
  output logic                evt_valid,
  output logic [EVT_W-1:0]    evt_data,
  input  logic                evt_ready,
  output logic                ovf,
  output logic                proto_err
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic             r_sync1, r_sync2, r_sync3, r_stb;
  logic [7:0]       r_byte;
  logic [TMO_W-1:0] r_tmo;
  kbd_state_t       r_state, w_state_nxt;
  logic             w_make, w_brk, w_ext, w_err, w_tmo_hit, w_ctrl_code;
  logic [4:0]       w_lookup;
  logic             w_hit, w_push, w_pop, w_full, w_empty;
  logic [3:0]       w_idx;

  // Stage 3 registers the edge so the FSM sees byte and strobe together.
  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_stb   <= 1'b0;
      r_byte  <= '0;
    end else begin
      r_sync1 <= rx_rdy;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_stb   <= r_sync2 & ~r_sync3;
      if (r_sync2 && !r_sync3)
        r_byte <= rx_byte;
    end
  end

  assign w_tmo_hit   = (r_tmo == C_TMO_LAST);
  assign w_ctrl_code = (r_byte == CODE_BAT_OK) || (r_byte == CODE_ACK) ||
                       (r_byte == CODE_ECHO)   || (r_byte == CODE_RESEND);

  always_comb begin
    w_state_nxt = r_state;
    w_make      = 1'b0;
    w_brk       = 1'b0;
    w_ext       = 1'b0;
    w_err       = 1'b0;
    if (r_stb) begin
      case (r_state)
        ST_IDLE: begin
          if (r_byte == PFX_EXT)      w_state_nxt = ST_EXT;
          else if (r_byte == PFX_BRK) w_state_nxt = ST_BRK;
          else if (!w_ctrl_code)      w_make      = 1'b1;
        end
        ST_EXT: begin
          if (r_byte == PFX_BRK) w_state_nxt = ST_EXT_BRK;
          else if (r_byte != PFX_EXT) begin
            w_make      = 1'b1;
            w_ext       = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_BRK, ST_EXT_BRK: begin
          w_state_nxt = ST_IDLE;
          if (r_byte == PFX_EXT || r_byte == PFX_BRK) begin
            w_err = 1'b1;
          end else begin
            w_brk = 1'b1;
            w_ext = (r_state == ST_EXT_BRK);
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end else if (r_state != ST_IDLE && w_tmo_hit) begin
      w_err       = 1'b1;
      w_state_nxt = ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      r_state   <= ST_IDLE;
      r_tmo     <= '0;
      proto_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      proto_err <= w_err;
      if (r_stb || r_state == ST_IDLE || w_tmo_hit)
        r_tmo <= '0;
      else
        r_tmo <= r_tmo + 1'b1;
    end
  end

  assign w_lookup = key_lookup(w_ext, r_byte);
  assign w_hit    = w_lookup[4];
  assign w_idx    = w_lookup[3:0];

`ifdef TYPEMATIC_FILTER_EN
  assign w_push = w_hit & (w_brk | (w_make & ~key_state[w_idx]));
`else
  assign w_push = w_hit & (w_brk | w_make);
`endif

  assign w_pop     = evt_valid & evt_ready;
  assign evt_valid = ~w_empty;

  always_ff @(posedge clk or negedge ar) begin
    if (!ar) begin
      key_state <= '0;
      ovf       <= 1'b0;
    end else begin
      if (w_hit && w_make)
        key_state[w_idx] <= 1'b1;
      else if (w_hit && w_brk)
        key_state[w_idx] <= 1'b0;
      if (w_push && w_full && !w_pop)
        ovf <= 1'b1;
    end
  end

  ps2_evt_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .ar    (ar),
    .push  (w_push),
    .din   ({w_brk, w_idx}),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .dout  (evt_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_ps2_key_ctrl.sv
// ============================================================================
// Module      : tb_ps2_key_ctrl
// Description : Self-checking bench for ps2_key_ctrl against a byte-level
//               behavioural model of the scan-code protocol.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ps2_key_ctrl;

  localparam int DEPTH = 4;
  localparam int TMO   = 200;

  logic       clk = 1'b0;
  logic       ar = 1'b0;
  logic       rx_rdy = 1'b0;
  logic       evt_ready = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [9:0] key_state;
  logic       evt_valid;
  logic [4:0] evt_data;
  logic       ovf;
  logic       proto_err;

  int passed = 0;
  int total  = 0;
  int err_pulses = 0;

  // model state
  bit         m_held[10];
  logic [4:0] m_q[$];
  bit         m_ovf;
  int         m_err;
  bit         m_ext, m_brk;
  logic [4:0] got_q[$];
  logic [8:0] key_code[10] = '{9'h175, 9'h172, 9'h16B, 9'h174, 9'h01D,
                               9'h01C, 9'h01B, 9'h023, 9'h029, 9'h076};

  ps2_key_ctrl #(
    .FIFO_DEPTH  (DEPTH),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .clk       (clk),
    .ar        (ar),
    .rx_byte   (rx_byte),
    .rx_rdy    (rx_rdy),
    .key_state (key_state),
    .evt_valid (evt_valid),
    .evt_data  (evt_data),
    .evt_ready (evt_ready),
    .ovf       (ovf),
    .proto_err (proto_err)
  );

  always #10 clk = ~clk;

  always @(posedge clk) if (proto_err === 1'b1) err_pulses++;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  function automatic int m_find(input bit ext, input logic [7:0] b);
    for (int i = 0; i < 10; i++)
      if (key_code[i] == {ext, b}) return i;
    return -1;
  endfunction

  function automatic logic [9:0] m_keys();
    logic [9:0] v;
    for (int i = 0; i < 10; i++) v[i] = m_held[i];
    return v;
  endfunction

  task automatic m_push(input logic [4:0] e);
    if (m_q.size() < DEPTH) m_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic m_reset();
    for (int i = 0; i < 10; i++) m_held[i] = 1'b0;
    m_q.delete();
    m_ovf = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    int k;
    if (b == 8'hE0 || b == 8'hF0) begin
      if (m_brk) begin
        m_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
      end else if (b == 8'hE0) m_ext = 1'b1;
      else m_brk = 1'b1;
    end else if (!m_ext && !m_brk &&
                 (b == 8'hAA || b == 8'hFA || b == 8'hEE || b == 8'hFE)) begin
      // controller replies carry no key information
    end else begin
      k = m_find(m_ext, b);
      if (k >= 0) begin
        if (m_brk) begin
          m_held[k] = 1'b0;
          m_push({1'b1, 4'(k)});
        end else begin
`ifdef TYPEMATIC_FILTER_EN
          if (!m_held[k]) m_push({1'b0, 4'(k)});
`else
          m_push({1'b0, 4'(k)});
`endif
          m_held[k] = 1'b1;
        end
      end
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_byte = b;
    rx_rdy  = 1'b1;
    repeat (6) @(negedge clk);
    rx_rdy = 1'b0;
    repeat (8) @(negedge clk);
    model_byte(b);
  endtask

  task automatic send_key(input int k, input bit brk);
    if (key_code[k][8]) send_byte(8'hE0);
    if (brk) send_byte(8'hF0);
    send_byte(key_code[k][7:0]);
  endtask

  // Collects DUT events only; comparisons live in each scenario.
  task automatic drain();
    got_q.delete();
    evt_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      if (evt_valid !== 1'b1) break;
      got_q.push_back(evt_data);
      @(negedge clk);
    end
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    ar = 1'b0;
    m_reset();
    repeat (3) @(negedge clk);
    total++; if (key_state !== 10'h0) $display("FAIL reset_key_state: got %h expected 000", key_state); else passed++;
    total++; if (evt_valid !== 1'b0) $display("FAIL reset_evt_valid: got %b expected 0", evt_valid); else passed++;
    total++; if (evt_data !== 5'h0) $display("FAIL reset_evt_data: got %h expected 00", evt_data); else passed++;
    total++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else passed++;
    total++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err: got %b expected 0", proto_err); else passed++;
    ar = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_make_break();
    send_byte(8'h1D);
    total++; if (key_state[4] !== 1'b1) $display("FAIL w_press_state: got %b expected 1", key_state[4]); else passed++;
    send_byte(8'hF0);
    send_byte(8'h1D);
    total++; if (key_state !== m_keys()) $display("FAIL w_release_state: got %h expected %h", key_state, m_keys()); else passed++;
    drain();
    total++; if (got_q.size() !== 2) $display("FAIL w_evt_count: got %0d expected 2", got_q.size()); else passed++;
    for (int i = 0; i < got_q.size() && i < m_q.size(); i++) begin
      total++; if (got_q[i] !== m_q[i]) $display("FAIL w_evt[%0d]: got %h expected %h", i, got_q[i], m_q[i]); else passed++;
    end
    m_q.delete();
    total++; if (err_pulses !== m_err) $display("FAIL w_proto_err: got %0d expected %0d", err_pulses, m_err); else passed++;
  endtask

  task automatic test_extended();
    send_byte(8'hE0); send_byte(8'h75);
    total++; if (key_state[0] !== 1'b1) $display("FAIL up_press_state: got %b expected 1", key_state[0]); else passed++;
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    send_byte(8'hE0); send_byte(8'hE0); send_byte(8'h74);
    total++; if (key_state !== m_keys()) $display("FAIL ext_state: got %h expected %h", key_state, m_keys()); else passed++;
    drain();
    total++; if (got_q.size() !== m_q.size()) $display("FAIL ext_evt_count: got %0d expected %0d", got_q.size(), m_q.size()); else passed++;
    for (int i = 0; i < got_q.size() && i < m_q.size(); i++) begin
      total++; if (got_q[i] !== m_q[i]) $display("FAIL ext_evt[%0d]: got %h expected %h", i, got_q[i], m_q[i]); else passed++;
    end
    m_q.delete();
    total++; if (evt_data !== 5'h0) $display("FAIL ext_empty_data: got %h expected 00", evt_data); else passed++;
  endtask

  task automatic test_overflow();
    logic [7:0] codes[5] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h29};
    for (int i = 0; i < 5; i++) send_byte(codes[i]);
    total++; if (ovf !== m_ovf) $display("FAIL ovf_flag: got %b expected %b", ovf, m_ovf); else passed++;
    total++; if (key_state !== m_keys()) $display("FAIL ovf_state: got %h expected %h", key_state, m_keys()); else passed++;
    total++; if (evt_valid !== 1'b1) $display("FAIL ovf_valid: got %b expected 1", evt_valid); else passed++;
    drain();
    total++; if (got_q.size() !== m_q.size()) $display("FAIL ovf_evt_count: got %0d expected %0d", got_q.size(), m_q.size()); else passed++;
    for (int i = 0; i < got_q.size() && i < m_q.size(); i++) begin
      total++; if (got_q[i] !== m_q[i]) $display("FAIL ovf_evt[%0d]: got %h expected %h", i, got_q[i], m_q[i]); else passed++;
    end
    m_q.delete();
    total++; if (evt_valid !== 1'b0) $display("FAIL ovf_drained: got %b expected 0", evt_valid); else passed++;
  endtask

  task automatic test_timeout();
    for (int k = 0; k < 10; k++) if (m_held[k]) send_key(k, 1'b1);
    drain();
    m_q.delete();
    send_byte(8'hF0);
    repeat (TMO + 20) @(negedge clk);
    if (m_ext || m_brk) begin
      m_err++;
      m_ext = 1'b0;
      m_brk = 1'b0;
    end
    total++; if (err_pulses !== m_err) $display("FAIL timeout_err: got %0d expected %0d", err_pulses, m_err); else passed++;
    send_byte(8'h29);
    drain();
    total++; if (got_q.size() !== 1 || got_q[0] !== 5'h08) $display("FAIL timeout_space: got %0d events head %h expected 1 event 08", got_q.size(), (got_q.size() > 0) ? got_q[0] : 5'h1F); else passed++;
    m_q.delete();
  endtask

  task automatic test_typematic();
    send_byte(8'hF0); send_byte(8'h1C);
    drain();
    m_q.delete();
    send_byte(8'h1C);
    send_byte(8'h1C);
    total++; if (key_state[5] !== 1'b1) $display("FAIL typ_state: got %b expected 1", key_state[5]); else passed++;
    drain();
    total++; if (got_q.size() !== m_q.size()) $display("FAIL typ_evt_count: got %0d expected %0d", got_q.size(), m_q.size()); else passed++;
    for (int i = 0; i < got_q.size() && i < m_q.size(); i++) begin
      total++; if (got_q[i] !== 5'h05) $display("FAIL typ_evt[%0d]: got %h expected 05", i, got_q[i]); else passed++;
    end
    m_q.delete();
  endtask

  task automatic test_random();
    int k, r;
    for (int it = 0; it < 30; it++) begin
      k = $urandom_range(0, 9);
      r = $urandom_range(0, 9);
      if (r < 6) send_key(k, 1'b0);
      else if (r < 8) send_key(k, 1'b1);
      else if (r == 8) begin send_byte(8'hF0); send_byte(8'hE0); end
      else send_byte(8'hAA);
      total++; if (key_state !== m_keys()) $display("FAIL rnd_state[%0d]: got %h expected %h", it, key_state, m_keys()); else passed++;
      if (it % 3 == 2) begin
        drain();
        total++; if (got_q.size() !== m_q.size()) $display("FAIL rnd_evt_count[%0d]: got %0d expected %0d", it, got_q.size(), m_q.size()); else passed++;
        for (int i = 0; i < got_q.size() && i < m_q.size(); i++) begin
          total++; if (got_q[i] !== m_q[i]) $display("FAIL rnd_evt[%0d.%0d]: got %h expected %h", it, i, got_q[i], m_q[i]); else passed++;
        end
        m_q.delete();
      end
    end
    total++; if (err_pulses !== m_err) $display("FAIL rnd_proto_err: got %0d expected %0d", err_pulses, m_err); else passed++;
    total++; if (ovf !== m_ovf) $display("FAIL rnd_ovf: got %b expected %b", ovf, m_ovf); else passed++;
  endtask

  task automatic test_reset_mid_seq();
    send_byte(8'h76);
    send_byte(8'hE0);
    @(negedge clk);
    ar = 1'b0;
    #3;
    m_reset();
    total++; if (key_state !== 10'h0) $display("FAIL mid_rst_state: got %h expected 000", key_state); else passed++;
    total++; if ({evt_valid, evt_data, ovf, proto_err} !== 8'h0) $display("FAIL mid_rst_outputs: got %h expected 00", {evt_valid, evt_data, ovf, proto_err}); else passed++;
    repeat (2) @(negedge clk);
    ar = 1'b1;
    send_byte(8'h75);
    total++; if (key_state !== 10'h0) $display("FAIL post_rst_state: got %h expected 000", key_state); else passed++;
    total++; if (evt_valid !== 1'b0) $display("FAIL post_rst_evt: got %b expected 0", evt_valid); else passed++;
    total++; if (err_pulses !== m_err) $display("FAIL post_rst_err: got %0d expected %0d", err_pulses, m_err); else passed++;
  endtask

  initial begin
    m_err = 0;
    test_reset();
    test_make_break();
    test_extended();
    test_overflow();
    test_timeout();
    test_typematic();
    test_random();
    test_reset_mid_seq();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
